// File: rtl/gost89_pkg.sv
// Purpose: shared types, constants and helpers for the GOST 28147-89 ECB core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, ROUNDS, key_idx() key-schedule lookup, rol11().
package gost89_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ROUNDS = 32;

    // Round-key index for round rnd. 7 - (rnd mod 8) is the bitwise inverse
    // of the low three bits. Encrypt reverses the order for the last eight
    // rounds; decrypt runs forward for the first eight only.
    function automatic logic [2:0] key_idx(input logic [4:0] rnd, input logic decrypt);
        logic [2:0] idx;
        if (decrypt) begin
            idx = (rnd < 5'd8) ? rnd[2:0] : ~rnd[2:0];
        end else begin
            idx = (rnd < 5'd24) ? rnd[2:0] : ~rnd[2:0];
        end
        return idx;
    endfunction

    function automatic logic [31:0] rol11(input logic [31:0] x);
        return {x[20:0], x[31:21]};
    endfunction

endpackage

// File: rtl/gost89_round.sv
// Purpose: one combinational GOST Feistel round (add key, substitute, rotate, xor, swap).
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: n1_i/n2_i halves in, rkey_i round key, sbox_i 8 rows x 64 bits,
//        n1_o/n2_o halves out.
module gost89_round
    import gost89_pkg::*;
(
    input  logic [31:0]  n1_i,
    input  logic [31:0]  n2_i,
    input  logic [31:0]  rkey_i,
    input  logic [511:0] sbox_i,
    output logic [31:0]  n1_o,
    output logic [31:0]  n2_o
);

    logic [31:0] sum;
    logic [31:0] sub;

    // Modular add, carry out of bit 31 dropped.
    assign sum = n1_i + rkey_i;

    for (genvar k = 0; k < 8; k++) begin : g_sbox
        gost89_sbox u_sbox (
            .row_i (sbox_i[64*k +: 64]),
            .nib_i (sum[4*k +: 4]),
            .nib_o (sub[4*k +: 4])
        );
    end

    assign n1_o = n2_i ^ rol11(sub);
    assign n2_o = n1_i;

endmodule

// File: rtl/gost89_sbox.sv
// Purpose: one 4-bit GOST S-box lookup driven by a 64-bit table row.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: row_i (16 x 4-bit entries, entry 0 in the top nibble), nib_i, nib_o.
module gost89_sbox (
    input  logic [63:0] row_i,
    input  logic [3:0]  nib_i,
    output logic [3:0]  nib_o
);

    // Entry j lives at bits [63-4j -: 4], so an identity row reads
    // 0x0123456789ABCDEF. Inverting the index turns that into a plain +: select.
    logic [3:0] slot;

    assign slot  = ~nib_i;
    assign nib_o = row_i[{slot, 2'b00} +: 4];

endmodule

// File: rtl/gost89_ecb_core.sv
// Purpose: iterative GOST 28147-89 ECB block cipher, UNROLL rounds per clock.
// Latency: out_valid rises 32/UNROLL clocks after the acceptance edge.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports: clk, rst (async, active-high); in_valid/in_ready with decrypt, key,
//        sbox, data_in; out_valid/out_ready with data_out; busy.
// Build option: define GOST89_DECRYPT_EN to honour the decrypt input;
//        without it the core always encrypts and decrypt is ignored.
module gost89_ecb_core
    import gost89_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [255:0] key,
    input  logic [511:0] sbox,
    input  logic [63:0]  data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("gost89_ecb_core: UNROLL must be 1, 2 or 4");
    end

    state_e         state_q, state_d;
    logic [4:0]     rnd_q;
    logic [31:0]    n1_q, n2_q;
    logic [255:0]   key_q;
    logic [511:0]   sbox_q;
    logic [63:0]    dout_q;
    logic           dec_w;
    logic           accept;
    logic           last_grp;

    assign accept   = in_valid && in_ready;
    assign last_grp = (rnd_q == 5'(ROUNDS - UNROLL));

`ifdef GOST89_DECRYPT_EN
    logic dec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else if (accept) begin
            dec_q <= decrypt;
        end
    end

    assign dec_w = dec_q;
`else
    logic unused_decrypt;

    assign unused_decrypt = decrypt;
    assign dec_w          = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_grp)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from the state register) ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    // ---------------- Round chain ----------------
    logic [31:0] n1_c [UNROLL+1];
    logic [31:0] n2_c [UNROLL+1];

    assign n1_c[0] = n1_q;
    assign n2_c[0] = n2_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [2:0]  idx;
        logic [31:0] rkey;

        assign idx  = key_idx(rnd_q + 5'(u), dec_w);
        assign rkey = key_q[{idx, 5'b00000} +: 32];

        gost89_round u_round (
            .n1_i   (n1_c[u]),
            .n2_i   (n2_c[u]),
            .rkey_i (rkey),
            .sbox_i (sbox_q),
            .n1_o   (n1_c[u+1]),
            .n2_o   (n2_c[u+1])
        );
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q  <= '0;
            n1_q   <= '0;
            n2_q   <= '0;
            key_q  <= '0;
            sbox_q <= '0;
            dout_q <= '0;
        end else if (accept) begin
            rnd_q  <= '0;
            n1_q   <= data_in[31:0];
            n2_q   <= data_in[63:32];
            key_q  <= key;
            sbox_q <= sbox;
        end else if (state_q == RUN) begin
            rnd_q <= rnd_q + 5'(UNROLL);
            n1_q  <= n1_c[UNROLL];
            n2_q  <= n2_c[UNROLL];
            // {N1, N2} order undoes the swap of the final round.
            if (last_grp) begin
                dout_q <= {n1_c[UNROLL], n2_c[UNROLL]};
            end
        end
    end

    assign data_out = dout_q;

endmodule
